// File: rtl/hazard_if.sv
// D-stage side of the hazard scoreboard: decoded instruction fields in,
// stall / forward-select / mult-div busy out.
interface hazard_if #(
  parameter int TNEW_W = 2,
  parameter int SELW   = 2
);
  logic              d_valid;
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic              d_rs_used;
  logic              d_rt_used;
  logic [TNEW_W-1:0] d_rs_tuse;
  logic [TNEW_W-1:0] d_rt_tuse;
  logic [4:0]        d_a3;
  logic              d_regwrite;
  logic [TNEW_W-1:0] d_tnew;
  logic [1:0]        d_md_start;
  logic              d_md_use;
  logic              flush;
  logic              stall;
  logic [SELW-1:0]   fwd_rs_sel;
  logic [SELW-1:0]   fwd_rt_sel;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
           d_a3, d_regwrite, d_tnew, d_md_start, d_md_use, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_rs_tuse, d_rt_tuse,
           d_a3, d_regwrite, d_tnew, d_md_start, d_md_use, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller beside the MIPS decode stage: tracks dest/wr/Tnew
// for NSTAGE downstream stages and owns the mult/div occupancy counter.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int TNEW_W   = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);
  localparam int SELW    = $clog2(NSTAGE + 1);
  localparam int CNT_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic [4:0]        a3;
    logic              wr;
    logic [TNEW_W-1:0] tnew;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [SELW-1:0]   idx;
    logic [TNEW_W-1:0] tnew;
  } match_t;

  entry_t           stage_q [1:NSTAGE];
  logic [CNT_W-1:0] md_cnt_q;

  match_t rs_m, rt_m;
  logic   rs_haz, rt_haz, md_stall, issue;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rs_m = '0;
    rt_m = '0;
    // Walk oldest to youngest so the youngest producer overwrites older hits.
    for (int k = NSTAGE; k >= 1; k--) begin
      if (hz.d_rs_used && hz.d_rs != 5'd0 &&
          stage_q[k].wr && stage_q[k].a3 == hz.d_rs) begin
        rs_m.hit  = 1'b1;
        rs_m.idx  = SELW'(k);
        rs_m.tnew = stage_q[k].tnew;
      end
      if (hz.d_rt_used && hz.d_rt != 5'd0 &&
          stage_q[k].wr && stage_q[k].a3 == hz.d_rt) begin
        rt_m.hit  = 1'b1;
        rt_m.idx  = SELW'(k);
        rt_m.tnew = stage_q[k].tnew;
      end
    end
  end

  assign rs_haz   = rs_m.hit && (rs_m.tnew > hz.d_rs_tuse);
  assign rt_haz   = rt_m.hit && (rt_m.tnew > hz.d_rt_tuse);
  assign md_stall = hz.d_valid && (hz.d_md_use || hz.d_md_start != 2'b00) && hz.md_busy;

  assign hz.stall      = hz.d_valid && (rs_haz || rt_haz || md_stall);
  assign hz.md_busy    = (md_cnt_q != '0);
  // A producer still computing (tnew > 0) is picked up by a later-stage mux.
  assign hz.fwd_rs_sel = (rs_m.hit && rs_m.tnew == '0) ? rs_m.idx : '0;
  assign hz.fwd_rt_sel = (rt_m.hit && rt_m.tnew == '0) ? rt_m.idx : '0;

  assign issue = hz.d_valid && !hz.stall && !hz.flush;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the shift is race-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the scoreboard array is a handful of flops, not a RAM, so it is
      // cleared on reset like any other register.
      for (int k = 1; k <= NSTAGE; k++) stage_q[k] <= '0;
      md_cnt_q <= '0;
    end else begin
      stage_q[1] <= issue ? entry_t'{a3: hz.d_a3, wr: hz.d_regwrite, tnew: hz.d_tnew}
                          : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        stage_q[k+1].a3   <= stage_q[k].a3;
        stage_q[k+1].wr   <= stage_q[k].wr;
        stage_q[k+1].tnew <= (stage_q[k].tnew != '0) ? stage_q[k].tnew - TNEW_W'(1) : '0;
      end

      if (issue && hz.d_md_start != 2'b00)
        md_cnt_q <= (hz.d_md_start == 2'b01) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
      else if (md_cnt_q != '0)
        md_cnt_q <= md_cnt_q - CNT_W'(1);
    end
  end
endmodule
